// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 definitions used by the key-schedule slice:
//     - AES_NR, KEY_W, WORD_W      : round count and data widths
//     - round_key_t                : one round key as four 32-bit words,
//                                    element [3] = W0 (bits 127:96) ... [0] = W3
//     - RCON_TABLE / rcon()        : round constants for rounds 1..10
//     - ks_state_t                 : controller state encoding
//     - gf_mul()                   : GF(2^8) multiply (AES polynomial 0x11b)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef logic [3:0][WORD_W-1:0] round_key_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } ks_state_t;

    localparam logic [7:0] RCON_TABLE [1:AES_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon is only defined for rounds 1..10; anything else contributes 0.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] value;
        value = 8'h00;
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            value = RCON_TABLE[rnd];
        end
        return value;
    endfunction

    // Shift-and-add multiply, reducing by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ acc;
            end
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_schedule_ctrl_if
//   Request / read bus of the round-key generator.
//     i_start      : request a key expansion (honoured only while idle)
//     i_key        : 128-bit cipher key, W0 in [127:96]
//     i_rd_idx     : round-key index to read
//     o_round_key  : registered round key for i_rd_idx
//     o_busy       : expansion in progress
//     o_done       : one-cycle pulse when the last round key is written
//     o_keys_valid : the key store holds a complete schedule
//   master = key source / round datapath side, slave = key_schedule_ctrl.
// -----------------------------------------------------------------------------
interface key_schedule_ctrl_if;

    logic                       i_start;
    logic [aes_pkg::KEY_W-1:0]  i_key;
    logic [3:0]                 i_rd_idx;
    logic [aes_pkg::KEY_W-1:0]  o_round_key;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_keys_valid;

    modport master (
        output i_start,
        output i_key,
        output i_rd_idx,
        input  o_round_key,
        input  o_busy,
        input  o_done,
        input  o_keys_valid
    );

    modport slave (
        input  i_start,
        input  i_key,
        input  i_rd_idx,
        output o_round_key,
        output o_busy,
        output o_done,
        output o_keys_valid
    );

endinterface

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
//   Combinational AES forward S-box: multiplicative inverse in GF(2^8)
//   followed by the AES affine transform.
//     a : input byte
//     s : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    // Inverse computed as a^254 with a fixed addition chain; 0 maps to 0.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
    end

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign s = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/key_round_step.sv
// -----------------------------------------------------------------------------
// key_round_step
//   One combinational AES-128 key-expansion round.
//     prev_key : previous round key (W0..W3)
//     rnd      : round index used to select Rcon (1..10)
//     next_key : following round key
//   temp = SubWord(RotWord(W3)) ^ {Rcon, 24'h0}; then a running xor chain.
// -----------------------------------------------------------------------------
module key_round_step
    import aes_pkg::*;
(
    input  round_key_t prev_key,
    input  logic [3:0] rnd,
    output round_key_t next_key
);

    logic [WORD_W-1:0] rot_word;
    logic [WORD_W-1:0] sub_word;
    logic [WORD_W-1:0] temp;

    // RotWord: {a0,a1,a2,a3} -> {a1,a2,a3,a0}; W3 lives in element [0].
    assign rot_word = {prev_key[0][23:0], prev_key[0][31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot_word[b*8 +: 8]),
            .s (sub_word[b*8 +: 8])
        );
    end

    assign temp = sub_word ^ {rcon(rnd), 24'h000000};

    // Each new word depends on the one just produced, so the chain is serial.
    always_comb begin
        next_key    = '0;
        next_key[3] = prev_key[3] ^ temp;
        next_key[2] = prev_key[2] ^ next_key[3];
        next_key[1] = prev_key[1] ^ next_key[2];
        next_key[0] = prev_key[0] ^ next_key[1];
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// key_schedule_ctrl
//   Sequential AES-128 round-key generator and key store. On an accepted
//   start the cipher key goes to slot 0, then one expansion round per clock
//   fills slots 1..NUM_ROUNDS. Round keys are read back by index with one
//   cycle of latency; the encrypt path walks the index up, the decrypt path
//   walks it down.
//   Ports:
//     i_clk : system clock, rising edge
//     i_rst : synchronous active-high reset (state and outputs only; the
//             key store keeps its contents)
//     bus   : key_schedule_ctrl_if.slave (start/key/read index in,
//             round key/busy/done/keys_valid out)
// -----------------------------------------------------------------------------
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int KEY_W      = aes_pkg::KEY_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    key_schedule_ctrl_if.slave   bus
);

    if (KEY_W != 128) begin : g_bad_key_w
        $error("key_schedule_ctrl: KEY_W must be 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > AES_NR) begin : g_bad_rounds
        $error("key_schedule_ctrl: NUM_ROUNDS must be in 1..10");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t   state;
    logic [3:0]  cnt;
    round_key_t  work_key;
    round_key_t  next_key;
    round_key_t  key_store [0:NUM_ROUNDS];
    logic        rd_in_range;

    logic              busy_q;
    logic              done_q;
    logic              keys_valid_q;
    logic [KEY_W-1:0]  round_key_q;

    wire accept = (state == IDLE) && bus.i_start;

    // work_key mirrors the most recently written slot so the round step
    // never needs a second read port on the store.
    key_round_step u_step (
        .prev_key (work_key),
        .rnd      (cnt),
        .next_key (next_key)
    );

    // NOTE: the key store and work_key are deliberately left out of reset; a
    // memory array with a reset cannot map onto RAM/flop-array primitives and
    // nothing here reads them before a fresh expansion rewrites them.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (accept) begin
                key_store[0] <= bus.i_key;
                work_key     <= bus.i_key;
            end else if (state == EXPAND) begin
                key_store[cnt] <= next_key;
                work_key       <= next_key;
            end
        end
    end

    assign rd_in_range = (bus.i_rd_idx <= LAST_IDX);

    // NOTE: all state and output registers use non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            round_key_q  <= '0;
        end else begin
            done_q <= 1'b0;

            // Gated by the registered valid flag: the first real read lands
            // one edge after keys_valid rises, and out-of-range reads give 0.
            round_key_q <= (keys_valid_q && rd_in_range) ? key_store[bus.i_rd_idx] : '0;

            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state        <= EXPAND;
                        cnt          <= 4'd1;
                        busy_q       <= 1'b1;
                        keys_valid_q <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (cnt == LAST_IDX) begin
                        state        <= IDLE;
                        cnt          <= 4'd0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        keys_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_keys_valid = keys_valid_q;
    assign bus.o_round_key  = round_key_q;

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
- Sequential AES-128 round-key generator and store.
- Loads a 128-bit cipher key and iterates one key-expansion round per clock to produce round keys 0..NUM_ROUNDS, keeping all of them in an internal key store.
- Serves round keys by index to the encrypt datapath (ascending index) and to the decrypt datapath (descending index).
- Sits between the key input register and the round datapaths.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; legal 1..10, and Rcon is defined only for rounds 1..10.
- KEY_W, 128, key and round-key width; fixed at 128, any other value is a synthesis error.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request a key expansion; sampled only while idle.
- i_key  input  128  cipher key; [127:96]=W0, [95:64]=W1, [63:32]=W2, [31:0]=W3; sampled on the edge that accepts i_start.
- i_rd_idx  input  4  round-key index to read, 0..NUM_ROUNDS.
- o_round_key  output  128  registered round key for i_rd_idx; same word order as i_key.
- o_busy  output  1  expansion in progress.
- o_done  output  1  one-cycle pulse when the last round key has been written.
- o_keys_valid  output  1  the whole key store holds a complete schedule.

Behaviour:
- Reset (i_rst=1 at an edge):
  - o_busy=0, o_done=0, o_keys_valid=0, o_round_key=0, round counter=0, state IDLE.
  - Key-store contents are not cleared.
  - Applies mid-expansion: the expansion aborts and nothing further is written.
- States:
  - IDLE -> EXPAND on i_start=1. On that edge: slot0<=i_key, counter<=1, o_busy<=1, o_keys_valid<=0.
  - EXPAND: each edge feeds the previous slot's four words, plus the counter as the Rcon index, through one expansion round and writes slot[counter]. Counter then increments.
  - EXPAND -> IDLE on the edge that writes slot[NUM_ROUNDS]. On that edge: o_busy<=0, o_done<=1, o_keys_valid<=1.
  - o_done clears on the following edge.
- Latency: i_start accepted at edge E0; slot k written at edge Ek; o_done and o_keys_valid are high after edge E(NUM_ROUNDS).
  - Default NUM_ROUNDS=10 gives 11 edges from start to complete.
- Expansion round for index r:
  - temp = SubWord(RotWord(W3)) xor Rcon(r), with Rcon(r) placed in bits [31:24].
  - W0' = W0 xor temp; W1' = W1 xor W0'; W2' = W2 xor W1'; W3' = W3 xor W2'.
- i_start rules:
  - Ignored while o_busy=1; i_key is not resampled.
  - Accepted while idle with o_keys_valid=1: this restarts the expansion, o_keys_valid drops on the accepting edge, and old slots are overwritten progressively.
  - i_start held high continuously: one expansion runs, then a new one is accepted on the first idle edge after completion. Since o_done is asserted on the completing edge, that first idle edge is the edge right after o_done goes high.
- Read port:
  - o_round_key <= (o_keys_valid && i_rd_idx<=NUM_ROUNDS) ? slot[i_rd_idx] : 0 at every edge.
  - One-cycle read latency.
  - The condition uses the registered o_keys_valid value, so the first non-zero read appears one edge after o_keys_valid rises.
  - Out-of-range index (11..15) reads 0. No X propagation.
- Decrypt use: the consumer drives i_rd_idx = NUM_ROUNDS-k. The block has no separate reverse mode.
- Simultaneous i_rst and i_start: reset wins.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10, KEY_W=128, WORD_W=32.
  - Round-key typedef: 4 x 32-bit words.
  - Rcon constant table for rounds 1..10.
  - State enum {IDLE, EXPAND}.
- One sub-module: key_round_step, a combinational single expansion round (RotWord, SubWord via the existing S-box block, Rcon xor, xor chain). The controller instantiates it once and reuses it every cycle.
- Counter, state machine, key store and read register live in key_schedule_ctrl.

Test Plan:
- FIPS-197 key:
  - i_key=2b7e151628aed2a6abf7158809cf4f3c, pulse i_start.
  - o_done pulses exactly 10 edges after the accepting edge; o_busy high for those 10 cycles.
  - idx1 reads a0fafe1788542cb123a339392a6c7605.
  - idx10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
  - idx0 reads back the key.
- Descending read after completion:
  - Sweep i_rd_idx 10..0, one per cycle.
  - o_round_key follows with 1-cycle latency and matches the FIPS-197 schedule.
  - idx 11..15 read 0.
- Start while busy:
  - Pulse i_start with key 000102030405060708090a0b0c0d0e0f at edge E3 of an expansion.
  - The request is ignored; the final schedule is still the FIPS-197 key's; o_done fires once.
- Reset mid-operation:
  - Assert i_rst at edge E5.
  - o_busy=0, o_keys_valid=0, o_round_key=0.
  - No o_done pulse.
  - A new start afterwards completes normally in 10 edges.
- Restart after valid:
  - Second start with key 000102030405060708090a0b0c0d0e0f.
  - o_keys_valid drops on the accepting edge.
  - idx10 then reads 13111d7fe3944a17f307a78b4d2b30c5.
- Held i_start high for 25 cycles:
  - Exactly two expansions complete; o_done pulses twice.
  - The second start is accepted on the edge right after the first o_done goes high.
